// File: rtl/doctor_hit_detector_if.sv
// Pixel-stream / collision bundle between the video pipeline and the hit detector.
interface doctor_hit_detector_if;
    logic               startOfFrame;
    logic        [10:0] pixelX;
    logic        [10:0] pixelY;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic               doc_DR;
    logic               maze_DR;
    logic               machine_DR;
    logic               patient_DR;
    logic               collision_doc_maze;
    logic               collision_doc_machine;
    logic               collision_doc_patient;
    logic               collision_machine_maze;
    logic         [3:0] HitEdgeCode;

    // Video side: drives the pixel stream, consumes the collision pulses.
    modport master (
        output startOfFrame, pixelX, pixelY, topLeftX, topLeftY,
        output doc_DR, maze_DR, machine_DR, patient_DR,
        input  collision_doc_maze, collision_doc_machine, collision_doc_patient,
        input  collision_machine_maze, HitEdgeCode
    );

    // Detector side.
    modport slave (
        input  startOfFrame, pixelX, pixelY, topLeftX, topLeftY,
        input  doc_DR, maze_DR, machine_DR, patient_DR,
        output collision_doc_maze, collision_doc_machine, collision_doc_patient,
        output collision_machine_maze, HitEdgeCode
    );
endinterface

// File: rtl/doctor_hit_detector.sv
// Per-frame collision accumulator: ORs per-pixel overlaps over a frame and emits one
// single-cycle pulse per collision type (plus the touched doctor edges) after startOfFrame.
module doctor_hit_detector #(
    parameter int OBJ_W  = 32,
    parameter int OBJ_H  = 32,
    parameter int EDGE_W = 4
) (
    input logic                 clk,
    input logic                 resetN,
    doctor_hit_detector_if.slave bus
);

    localparam logic signed [11:0] ObjW     = 12'(OBJ_W);
    localparam logic signed [11:0] ObjH     = 12'(OBJ_H);
    localparam logic signed [11:0] EdgeW    = 12'(EDGE_W);
    localparam logic signed [11:0] RightAt  = 12'(OBJ_W - EDGE_W);
    localparam logic signed [11:0] BottomAt = 12'(OBJ_H - EDGE_W);

    typedef enum logic [1:0] {StIdle, StAccum, StEmit} state_e;

    // Stage-0 registers
    logic        [10:0] pix_x_q, pix_y_q;
    logic signed [10:0] tl_x_q, tl_y_q;
    logic               doc_q, maze_q, machine_q, patient_q;

    // Frame state
    state_e      state_q;
    logic  [3:0] acc_q;        // {doc_maze, doc_machine, doc_patient, machine_maze}
    logic  [3:0] acc_edge_q;   // {left, top, right, bottom}
    logic  [3:0] pend_q;
    logic  [3:0] pend_edge_q;

    logic signed [11:0] dx, dy;
    logic               in_box;
    logic         [3:0] edge_bits;
    logic         [3:0] hits;
    logic               doc_hit;
    logic         [3:0] edge_hit;
    logic               emit;

    // Register the incoming pixel, draw requests and sprite position every cycle.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            pix_x_q   <= '0;
            pix_y_q   <= '0;
            tl_x_q    <= '0;
            tl_y_q    <= '0;
            doc_q     <= 1'b0;
            maze_q    <= 1'b0;
            machine_q <= 1'b0;
            patient_q <= 1'b0;
        end else begin
            pix_x_q   <= bus.pixelX;
            pix_y_q   <= bus.pixelY;
            tl_x_q    <= bus.topLeftX;
            tl_y_q    <= bus.topLeftY;
            doc_q     <= bus.doc_DR;
            maze_q    <= bus.maze_DR;
            machine_q <= bus.machine_DR;
            patient_q <= bus.patient_DR;
        end
    end

    // Pixel position relative to the sprite: pixel is unsigned, top-left is signed.
    assign dx = $signed({1'b0, pix_x_q}) - $signed({tl_x_q[10], tl_x_q});
    assign dy = $signed({1'b0, pix_y_q}) - $signed({tl_y_q[10], tl_y_q});

    // Edge decode and per-pixel hits on stage-0 values.
    always_comb begin
        in_box    = doc_q && !dx[11] && (dx < ObjW) && !dy[11] && (dy < ObjH);
        edge_bits = 4'b0000;
        if (in_box) begin
            edge_bits = {dx < EdgeW, dy < EdgeW, dx >= RightAt, dy >= BottomAt};
        end
        hits     = {doc_q & maze_q, doc_q & machine_q, doc_q & patient_q, machine_q & maze_q};
        doc_hit  = |hits[3:1];
        // Machine-maze overlaps never say anything about the doctor's edges.
        edge_hit = doc_hit ? edge_bits : 4'b0000;
    end

    // Frame FSM: accumulate, latch on startOfFrame (current hits included), emit one cycle.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            acc_edge_q  <= '0;
            pend_q      <= '0;
            pend_edge_q <= '0;
        end else if (bus.startOfFrame) begin
            // A new latch always wins, even on the emit cycle of the previous frame.
            pend_q      <= acc_q | hits;
            pend_edge_q <= acc_edge_q | edge_hit;
            acc_q       <= '0;
            acc_edge_q  <= '0;
            state_q     <= StEmit;
        end else begin
            acc_q       <= acc_q | hits;
            acc_edge_q  <= acc_edge_q | edge_hit;
            state_q     <= StAccum;
        end
    end

    // Outputs decode from registers only; they are live just during the emit cycle.
    assign emit                       = (state_q == StEmit);
    assign bus.collision_doc_maze     = emit & pend_q[3];
    assign bus.collision_doc_machine  = emit & pend_q[2];
    assign bus.collision_doc_patient  = emit & pend_q[1];
    assign bus.collision_machine_maze = emit & pend_q[0];
    assign bus.HitEdgeCode            = (emit && (|pend_q[3:1])) ? pend_edge_q : 4'b0000;

endmodule

// File: tb/tb_doctor_hit_detector.sv
// Self-checking bench for doctor_hit_detector: directed scenarios plus a randomized run
// against a frame-level model (each pixel's effect joins the open frame when presented).
module tb_doctor_hit_detector;

    localparam int OBJ_W  = 32;
    localparam int OBJ_H  = 32;
    localparam int EDGE_W = 4;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    doctor_hit_detector_if bus();

    doctor_hit_detector #(
        .OBJ_W (OBJ_W),
        .OBJ_H (OBJ_H),
        .EDGE_W(EDGE_W)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Doctor position used for pixels presented from now on.
    int tlx = 100;
    int tly = 100;

    // Model: open-frame flags/edges and the outputs expected in the cycle after a step.
    logic [3:0] m_flags = 4'b0;   // {doc_maze, doc_machine, doc_patient, machine_maze}
    logic [3:0] m_edges = 4'b0;   // {left, top, right, bottom}
    logic [7:0] m_exp   = 8'b0;   // {four pulses, HitEdgeCode}

    // Effect of one presented pixel on its frame: {flags, edges}.
    function automatic logic [7:0] pixel_effect(int px, int py, bit doc, bit maze, bit mach,
                                                bit pat);
        logic [3:0] f;
        logic [3:0] e;
        int dx;
        int dy;
        f  = {doc & maze, doc & mach, doc & pat, mach & maze};
        e  = 4'b0;
        dx = px - tlx;
        dy = py - tly;
        if ((f[3] | f[2] | f[1]) && dx >= 0 && dx < OBJ_W && dy >= 0 && dy < OBJ_H) begin
            e[3] = (dx < EDGE_W);
            e[2] = (dy < EDGE_W);
            e[1] = (dx >= OBJ_W - EDGE_W);
            e[0] = (dy >= OBJ_H - EDGE_W);
        end
        return {f, e};
    endfunction

    function automatic logic [7:0] dut_out();
        return {bus.collision_doc_maze, bus.collision_doc_machine, bus.collision_doc_patient,
                bus.collision_machine_maze, bus.HitEdgeCode};
    endfunction

    // Drive one cycle, update the model, sample #1 after the edge.
    task automatic step(input bit rst, input bit sof, input int px, input int py,
                        input bit doc, input bit maze, input bit mach, input bit pat);
        logic [7:0] eff;
        resetN           = !rst;
        bus.startOfFrame = sof;
        bus.pixelX       = 11'(px);
        bus.pixelY       = 11'(py);
        bus.topLeftX     = 11'(tlx);
        bus.topLeftY     = 11'(tly);
        bus.doc_DR       = doc;
        bus.maze_DR      = maze;
        bus.machine_DR   = mach;
        bus.patient_DR   = pat;
        eff = pixel_effect(px, py, doc, maze, mach, pat);
        if (rst) begin
            // Both the in-flight pixel and the one presented now are lost.
            m_flags = 4'b0;
            m_edges = 4'b0;
            m_exp   = 8'b0;
        end else if (sof) begin
            m_exp   = {m_flags, (|m_flags[3:1]) ? m_edges : 4'b0};
            m_flags = eff[7:4];
            m_edges = eff[3:0];
        end else begin
            m_exp   = 8'b0;
            m_flags = m_flags | eff[7:4];
            m_edges = m_edges | eff[3:0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit sof);
        for (int i = 0; i < n; i++) step(1'b0, sof, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 101, 116, 1'b1, 1'b1, 1'b1, 1'b1);
        n_tests++;
        if (dut_out() !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", dut_out(), 8'b0);
        end
        idle(1, 1'b1);
        n_tests++;
        if (dut_out() !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_first_sof: got %b expected %b", dut_out(), 8'b0);
        end
        idle(2, 1'b0);
    endtask

    task automatic test_left_edge();
        tlx = 100;
        tly = 100;
        idle(1, 1'b1);
        idle(3, 1'b0);
        step(1'b0, 1'b0, 101, 116, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b0);
        idle(1, 1'b1);
        n_tests++;
        if (dut_out() !== 8'b1000_1000 || m_exp !== 8'b1000_1000) begin
            n_fail++;
            $display("FAIL left_edge: got %b expected %b", dut_out(), 8'b1000_1000);
        end
        idle(1, 1'b0);
        n_tests++;
        if (dut_out() !== 8'b0) begin
            n_fail++;
            $display("FAIL left_edge_one_cycle: got %b expected %b", dut_out(), 8'b0);
        end
    endtask

    task automatic test_corner();
        step(1'b0, 1'b0, 131, 131, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);
        idle(1, 1'b1);
        n_tests++;
        if (dut_out() !== 8'b0100_0011) begin
            n_fail++;
            $display("FAIL corner: got %b expected %b", dut_out(), 8'b0100_0011);
        end
        idle(1, 1'b0);
    endtask

    task automatic test_mm_and_patient();
        step(1'b0, 1'b0, 500, 500, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b0);
        step(1'b0, 1'b0, 115, 100, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b0);
        idle(1, 1'b1);
        n_tests++;
        if (dut_out() !== 8'b0011_0100) begin
            n_fail++;
            $display("FAIL mm_and_patient: got %b expected %b", dut_out(), 8'b0011_0100);
        end
        idle(1, 1'b0);
    endtask

    task automatic test_clear_between_frames();
        step(1'b0, 1'b0, 120, 105, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(1, 1'b1);
        n_tests++;
        if (dut_out() !== m_exp || dut_out() === 8'b0) begin
            n_fail++;
            $display("FAIL clear_frame1: got %b expected %b", dut_out(), m_exp);
        end
        idle(5, 1'b0);
        idle(1, 1'b1);
        n_tests++;
        if (dut_out() !== 8'b0) begin
            n_fail++;
            $display("FAIL clear_frame2: got %b expected %b", dut_out(), 8'b0);
        end
        idle(1, 1'b0);
    endtask

    task automatic test_hit_before_sof();
        idle(2, 1'b0);
        step(1'b0, 1'b0, 100, 110, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b1);
        n_tests++;
        if (dut_out() !== 8'b1000_1000) begin
            n_fail++;
            $display("FAIL hit_before_sof: got %b expected %b", dut_out(), 8'b1000_1000);
        end
        idle(3, 1'b0);
        idle(1, 1'b1);
        n_tests++;
        if (dut_out() !== 8'b0) begin
            n_fail++;
            $display("FAIL hit_before_sof_next: got %b expected %b", dut_out(), 8'b0);
        end
        idle(1, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        step(1'b0, 1'b0, 110, 110, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b1);
        n_tests++;
        if (dut_out() !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got %b expected %b", dut_out(), 8'b0);
        end
        idle(1, 1'b0);
        n_tests++;
        if (dut_out() !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_mid_frame_after: got %b expected %b", dut_out(), 8'b0);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b0, 100, 100, 1'b1, 1'b1, 1'b0, 1'b0);
        // The pixel presented on the SOF cycle belongs to the next frame.
        step(1'b0, 1'b1, 131, 100, 1'b1, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (dut_out() !== 8'b1000_1100) begin
            n_fail++;
            $display("FAIL back_to_back_first: got %b expected %b", dut_out(), 8'b1000_1100);
        end
        idle(1, 1'b1);
        n_tests++;
        if (dut_out() !== 8'b0010_0110) begin
            n_fail++;
            $display("FAIL back_to_back_second: got %b expected %b", dut_out(), 8'b0010_0110);
        end
        idle(1, 1'b0);
        n_tests++;
        if (dut_out() !== 8'b0) begin
            n_fail++;
            $display("FAIL back_to_back_end: got %b expected %b", dut_out(), 8'b0);
        end
    endtask

    task automatic test_random();
        int gap;
        int dens;
        int px;
        int py;
        bit sof;
        bit rst;
        bit doc, maze, mach, pat;
        gap  = 10;
        dens = 2;
        for (int i = 0; i < 3000; i++) begin
            sof = (gap == 0);
            if (sof) begin
                gap  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(3, 30));
                dens = int'($urandom_range(0, 4));
            end else begin
                gap--;
            end
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 199) == 0) begin
                tlx = int'($urandom_range(0, 950)) - 50;
                tly = int'($urandom_range(0, 950)) - 50;
            end
            px = tlx + int'($urandom_range(0, 43)) - 6;
            py = tly + int'($urandom_range(0, 43)) - 6;
            if (px < 0) px = 0;
            if (py < 0) py = 0;
            doc  = (int'($urandom_range(0, 7)) < dens);
            maze = (int'($urandom_range(0, 7)) < dens);
            mach = (int'($urandom_range(0, 7)) < dens);
            pat  = (int'($urandom_range(0, 7)) < dens);
            step(rst, sof, px, py, doc, maze, mach, pat);
            n_tests++;
            if (dut_out() !== m_exp) begin
                n_fail++;
                $display("FAIL random[%0d]: got %b expected %b", i, dut_out(), m_exp);
            end
        end
    endtask

    initial begin
        bus.startOfFrame = 1'b0;
        bus.pixelX       = '0;
        bus.pixelY       = '0;
        bus.topLeftX     = '0;
        bus.topLeftY     = '0;
        bus.doc_DR       = 1'b0;
        bus.maze_DR      = 1'b0;
        bus.machine_DR   = 1'b0;
        bus.patient_DR   = 1'b0;
        test_reset();
        test_left_edge();
        test_corner();
        test_mm_and_patient();
        test_clear_between_frames();
        test_hit_before_sof();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
